// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LS memory port arbiter: mem_rw codes, FSM states, owner id.
package mem_port_arbiter_pkg;

  typedef enum logic [3:0] {
    MemNoRw = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } mem_rw_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnLs
  } owner_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: load extend, store strobe/replicate, misalign detect.
module mem_lane_fmt
  import mem_port_arbiter_pkg::*;
(
  input  logic [3:0]  mem_rw,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_write,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend or replicate according to the access code.
  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    is_write  = 1'b0;
    wstrb     = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    misalign  = 1'b0;
    case (mem_rw_e'(mem_rw))
      MemLb:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      MemLbu: rdata_ext = {24'h0, byte_sel};
      MemLh: begin
        rdata_ext = {{16{half_sel[15]}}, half_sel};
        misalign  = addr_lo[0];
      end
      MemLhu: begin
        rdata_ext = {16'h0, half_sel};
        misalign  = addr_lo[0];
      end
      MemLw: begin
        rdata_ext = rdata;
        misalign  = |addr_lo;
      end
      MemSb: begin
        is_write  = 1'b1;
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MemSh: begin
        is_write  = 1'b1;
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      MemSw: begin
        is_write  = 1'b1;
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        misalign  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store over a gnt/rvalid handshake.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit          LSU_PRIO = 1'b1,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic [3:0]        ls_mem_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        ls_valid, pick_ls, in_idle;
  logic [3:0]  fmt_rw;
  logic [1:0]  fmt_addr_lo;
  logic        fmt_is_write, fmt_misalign;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata, fmt_rdata;

  // Fetches are always word-aligned; the low address bits are deliberately dropped.
  logic unused_if_addr_lo;
  assign unused_if_addr_lo = ^if_addr[1:0];

  assign in_idle  = (state_q == StIdle);
  assign ls_valid = ls_req && (mem_rw_e'(ls_mem_rw) != MemNoRw);
  // On a tie LS wins if prioritised, otherwise whoever was not served last wins.
  assign pick_ls  = ls_valid && (!if_req || LSU_PRIO || (rr_last_q == OwnIf));

  // In IDLE the formatter looks at the live LS request to catch misalignment before any access.
  assign fmt_rw      = in_idle ? ls_mem_rw : rw_q;
  assign fmt_addr_lo = in_idle ? ls_addr[1:0] : addr_q[1:0];

  mem_lane_fmt u_fmt (
    .mem_rw    (fmt_rw),
    .addr_lo   (fmt_addr_lo),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .is_write  (fmt_is_write),
    .wstrb     (fmt_wstrb),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .misalign  (fmt_misalign)
  );

  // State and transaction registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= OwnIf;
      rr_last_q <= OwnIf;
      addr_q    <= '0;
      rw_q      <= MemNoRw;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state: arbitrate in IDLE, sequence gnt/rvalid, release in RESP.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (ls_valid || if_req) begin
          err_d   = 1'b0;
          rdata_d = 32'h0;
          if (pick_ls) begin
            owner_d = OwnLs;
            addr_d  = ls_addr;
            rw_d    = ls_mem_rw;
            wdata_d = ls_wdata;
            if (fmt_misalign) begin
              err_d   = 1'b1;
              state_d = StResp;
            end else begin
              state_d = StReq;
            end
          end else begin
            // A fetch is a plain word load, so the formatter passes the word through.
            owner_d = OwnIf;
            addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
            rw_d    = MemLw;
            wdata_d = 32'h0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          rdata_d = fmt_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        rr_last_d = owner_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so that everything reads zero outside its own phase.
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_we    = mem_req && fmt_is_write;
    mem_wstrb = mem_we ? fmt_wstrb : 4'b0000;
    mem_wdata = mem_we ? fmt_wdata : 32'h0;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    if_done   = (state_q == StResp) && (owner_q == OwnIf);
    ls_done   = (state_q == StResp) && (owner_q == OwnLs);
    ls_err    = ls_done && err_q;
    if_rdata  = if_done ? rdata_q : 32'h0;
    ls_rdata  = ls_done ? rdata_q : 32'h0;
    stall     = (if_req | ls_req) & ~(if_done | ls_done);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench: dut 0 has LS priority, dut 1 is round-robin.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req     [2];
  logic [31:0] if_addr    [2];
  logic [31:0] if_rdata   [2];
  logic        if_done    [2];
  logic        ls_req     [2];
  logic [3:0]  ls_mem_rw  [2];
  logic [31:0] ls_addr    [2];
  logic [31:0] ls_wdata   [2];
  logic [31:0] ls_rdata   [2];
  logic        ls_done    [2];
  logic        ls_err     [2];
  logic        mem_req    [2];
  logic        mem_we     [2];
  logic [3:0]  mem_wstrb  [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic        mem_gnt    [2];
  logic        mem_rvalid [2];
  logic [31:0] mem_rdata  [2];
  logic        stall      [2];

  mem_port_arbiter #(.LSU_PRIO(1'b1), .ADDR_W(32)) u_dut_prio (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_done(if_done[0]),
    .ls_req(ls_req[0]), .ls_mem_rw(ls_mem_rw[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
    .ls_rdata(ls_rdata[0]), .ls_done(ls_done[0]), .ls_err(ls_err[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_wstrb(mem_wstrb[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_gnt(mem_gnt[0]), .mem_rvalid(mem_rvalid[0]),
    .mem_rdata(mem_rdata[0]), .stall(stall[0])
  );

  mem_port_arbiter #(.LSU_PRIO(1'b0), .ADDR_W(32)) u_dut_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_done(if_done[1]),
    .ls_req(ls_req[1]), .ls_mem_rw(ls_mem_rw[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
    .ls_rdata(ls_rdata[1]), .ls_done(ls_done[1]), .ls_err(ls_err[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_wstrb(mem_wstrb[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_gnt(mem_gnt[1]), .mem_rvalid(mem_rvalid[1]),
    .mem_rdata(mem_rdata[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference rules, expressed as plain arithmetic on access size.
  function automatic int unsigned acc_size(mem_rw_e rw);
    case (rw)
      MemLb, MemLbu, MemSb: return 1;
      MemLh, MemLhu, MemSh: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit is_st(mem_rw_e rw);
    return rw inside {MemSb, MemSh, MemSw};
  endfunction

  function automatic bit misaligned(mem_rw_e rw, logic [31:0] a);
    return (a % acc_size(rw)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(mem_rw_e rw, logic [31:0] a, logic [31:0] w);
    int unsigned sh_b, sh_h, b, h;
    sh_b = 8 * (a % 4);
    sh_h = 16 * ((a % 4) / 2);
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (rw)
      MemLb:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      MemLbu:  return b;
      MemLh:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      MemLhu:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(mem_rw_e rw, logic [31:0] a);
    int unsigned m;
    if (!is_st(rw)) return 4'b0000;
    m = ((1 << acc_size(rw)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_wdata(mem_rw_e rw, logic [31:0] w);
    case (acc_size(rw))
      1:       return (w & 32'hFF) * 32'h0101_0101;
      2:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // Observations captured by the memory responder during one access.
  bit          cap_seen, cap_we, cap_err, stall_ok, stable_ok;
  logic [3:0]  cap_strb;
  logic [31:0] cap_addr, cap_wdata, cap_if_rdata, cap_ls_rdata;

  // Acts as the memory for dut d until a done pulse, with gnt/rvalid delayed by gd/vd cycles.
  task automatic run(input int d, input logic [31:0] word, input int gd, input int vd,
                     output bit got_if, output bit got_ls, output int cyc);
    int phase;
    int cnt;
    phase = 0; cnt = 0; got_if = 0; got_ls = 0; cyc = 0;
    cap_seen = 0; stall_ok = 1; stable_ok = 1;
    while (!(got_if || got_ls) && cyc < 50) begin
      @(negedge clk);
      cyc++;
      mem_gnt[d]    = 1'b0;
      mem_rvalid[d] = 1'b0;
      if (if_done[d] || ls_done[d]) begin
        got_if       = if_done[d];
        got_ls       = ls_done[d];
        cap_if_rdata = if_rdata[d];
        cap_ls_rdata = ls_rdata[d];
        cap_err      = ls_err[d];
        if (stall[d]) stall_ok = 0;
      end else begin
        if (!stall[d]) stall_ok = 0;
        if (phase == 0 && mem_req[d]) begin
          if (cap_seen && (cap_we != mem_we[d] || cap_strb != mem_wstrb[d] ||
                           cap_addr != mem_addr[d] || cap_wdata != mem_wdata[d]))
            stable_ok = 0;
          cap_seen  = 1;
          cap_we    = mem_we[d];
          cap_strb  = mem_wstrb[d];
          cap_addr  = mem_addr[d];
          cap_wdata = mem_wdata[d];
          if (cnt >= gd) begin
            mem_gnt[d] = 1'b1;
            phase = 1;
            cnt = 0;
          end else begin
            cnt++;
            mem_rvalid[d] = 1'($urandom_range(0, 1));
          end
        end else if (phase == 1) begin
          if (cnt >= vd) begin
            mem_rvalid[d] = 1'b1;
            mem_rdata[d]  = word;
            phase = 2;
          end else begin
            cnt++;
            mem_gnt[d] = 1'($urandom_range(0, 1));
          end
        end
      end
    end
    if (!(got_if || got_ls)) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic ls_op(input int d, input mem_rw_e rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int gd, input int vd);
    bit gi, gl, mis;
    int cyc;
    ls_req[d] = 1'b1; ls_mem_rw[d] = rw; ls_addr[d] = addr; ls_wdata[d] = wdata;
    run(d, word, gd, vd, gi, gl, cyc);
    ls_req[d] = 1'b0; ls_mem_rw[d] = MemNoRw;
    mis = misaligned(rw, addr);
    check("ls_done", 32'(gl), 32'd1);
    check("if_done_spurious", 32'(gi), 32'd0);
    check("ls_err", 32'(cap_err), 32'(mis));
    check("mem_req_seen", 32'(cap_seen), 32'(!mis));
    check("ls_latency", cyc, mis ? 1 : 3 + gd + vd);
    check("ls_stall", 32'(stall_ok), 32'd1);
    if (!mis) begin
      check("ls_mem_stable", 32'(stable_ok), 32'd1);
      check("ls_mem_addr", cap_addr, {addr[31:2], 2'b00});
      check("ls_mem_we", 32'(cap_we), 32'(is_st(rw)));
      check("ls_mem_wstrb", 32'(cap_strb), 32'(exp_strb(rw, addr)));
      if (is_st(rw)) check("ls_mem_wdata", cap_wdata, exp_wdata(rw, wdata));
      else check("ls_rdata", cap_ls_rdata, exp_load(rw, addr, word));
    end
    @(negedge clk);
  endtask

  task automatic if_op(input int d, input logic [31:0] addr, input logic [31:0] word,
                       input int gd, input int vd);
    bit gi, gl;
    int cyc;
    if_req[d] = 1'b1; if_addr[d] = addr;
    run(d, word, gd, vd, gi, gl, cyc);
    if_req[d] = 1'b0;
    check("if_done", 32'(gi), 32'd1);
    check("ls_done_spurious", 32'(gl), 32'd0);
    check("if_latency", cyc, 3 + gd + vd);
    check("if_mem_addr", cap_addr, {addr[31:2], 2'b00});
    check("if_mem_we", 32'(cap_we), 32'd0);
    check("if_mem_wstrb", 32'(cap_strb), 32'd0);
    check("if_rdata", cap_if_rdata, word);
    check("if_stall", 32'(stall_ok), 32'd1);
    @(negedge clk);
    check("if_stall_after", 32'(stall[d]), 32'd0);
  endtask

  // Both requesters hold three accesses each; model predicts the service order.
  task automatic tie_test(input int d, input bit prio);
    int  n_if, n_ls, cyc;
    bit  last_ls, exp_ls, gi, gl;
    n_if = 3; n_ls = 3; last_ls = 0;
    if_req[d] = 1'b1; if_addr[d] = 32'h0000_1000;
    ls_req[d] = 1'b1; ls_mem_rw[d] = MemLw; ls_addr[d] = 32'h0000_2000; ls_wdata[d] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (n_if > 0 && n_ls > 0) exp_ls = prio ? 1'b1 : !last_ls;
      else exp_ls = (n_ls > 0);
      run(d, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), gi, gl, cyc);
      check("tie_one_done", 32'(gi ^ gl), 32'd1);
      check("tie_order", 32'(gl), 32'(exp_ls));
      last_ls = gl;
      if (gl) begin
        n_ls--;
        if (n_ls == 0) begin ls_req[d] = 1'b0; ls_mem_rw[d] = MemNoRw; end
      end else begin
        n_if--;
        if (n_if == 0) if_req[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  mem_rw_e ops [8] = '{MemLb, MemLbu, MemLh, MemLhu, MemLw, MemSb, MemSh, MemSw};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit bad_noreq;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 0; if_addr[d] = 0; ls_req[d] = 0; ls_mem_rw[d] = MemNoRw; ls_addr[d] = 0;
      ls_wdata[d] = 0; mem_gnt[d] = 0; mem_rvalid[d] = 0; mem_rdata[d] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req[0]), 32'd0);
    check("rst_if_done", 32'(if_done[0]), 32'd0);
    check("rst_ls_done", 32'(ls_done[0]), 32'd0);
    check("rst_stall", 32'(stall[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the block description.
    if_op(0, 32'h0000_0100, 32'h0050_0093, 0, 0);
    check("dir_if_rdata", cap_if_rdata, 32'h0050_0093);
    ls_op(0, MemLb, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0, 0);
    check("dir_lb", cap_ls_rdata, 32'hFFFF_FF80);
    ls_op(0, MemLbu, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0, 0);
    check("dir_lbu", cap_ls_rdata, 32'h0000_0080);
    ls_op(0, MemLh, 32'h0000_0202, 32'h0, 32'h80FF_0000, 0, 0);
    check("dir_lh", cap_ls_rdata, 32'hFFFF_80FF);
    ls_op(0, MemSh, 32'h0000_0302, 32'h1234_ABCD, 32'h0, 1, 1);
    check("dir_sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("dir_sh_wstrb", 32'(cap_strb), 32'h0000_000C);
    check("dir_sh_addr", cap_addr, 32'h0000_0300);
    ls_op(0, MemLw, 32'h0000_0401, 32'h0, 32'h0, 0, 0);

    // A no_rw code with ls_req high is not a request.
    ls_req[0] = 1'b1; ls_mem_rw[0] = MemNoRw; ls_addr[0] = 32'h40;
    bad_noreq = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req[0] || ls_done[0] || if_done[0]) bad_noreq = 1;
    end
    check("no_rw_ignored", 32'(bad_noreq), 32'd0);
    ls_req[0] = 1'b0;
    @(negedge clk);

    // Tie-break order under both priority settings.
    tie_test(0, 1'b1);
    tie_test(1, 1'b0);

    // Reset while waiting for rvalid, followed by a stale rvalid.
    ls_req[0] = 1'b1; ls_mem_rw[0] = MemLw; ls_addr[0] = 32'h0000_0500;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req[0]), 32'd1);
    mem_gnt[0] = 1'b1;
    @(negedge clk);
    mem_gnt[0] = 1'b0; rst_n = 1'b0; ls_req[0] = 1'b0; ls_mem_rw[0] = MemNoRw;
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_req[0]), 32'd0);
    check("rst_mid_ls_done", 32'(ls_done[0]), 32'd0);
    check("rst_mid_ls_rdata", ls_rdata[0], 32'd0);
    check("rst_mid_stall", 32'(stall[0]), 32'd0);
    rst_n = 1'b1; mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid[0] = 1'b0;
    check("stale_rvalid_done", 32'(ls_done[0]), 32'd0);
    @(negedge clk);
    check("stale_rvalid_done2", 32'(ls_done[0] | if_done[0]), 32'd0);
    ls_op(0, MemLw, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 0, 0);

    // Randomised single accesses on both instances.
    for (int i = 0; i < 80; i++) begin
      int d;
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0)
        if_op(d, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        ls_op(d, ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
